// File: rtl/fc_pass_scheduler.sv
// fc_pass_scheduler
//   Sequences one fully-connected layer pass. A start pulse walks every
//   output-neuron group: it issues the input/weight read beats, aligns the
//   bank select / MAC enable / accumulator sload with the returning read data,
//   drains the read and MAC pipelines, then writes the group result under an
//   out_ready handshake. done pulses once after the final group write.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset, clears all state and outputs
//   start        pass request, sampled only while idle
//   abort        synchronous cancel, back to idle next cycle, no write/done
//   out_ready    result memory can take a write this cycle
//   busy         pass in progress (cycle after accepted start .. final write)
//   done         one-cycle pulse after the last group write
//   rden         read enable for input-neuron and weight memories
//   in_addr      input-neuron bank address (shared by ports a and b)
//   weight_addr  weight address
//   bank_sel     PI bank select for the q_a/q_b muxes, aligned to read data
//   enable_mult  MAC input valid, aligned to read data
//   accum_sload  restart accumulation on the first data beat of a group
//   out_wren     result write strobe
//   out_addr     group index being written
module fc_pass_scheduler #(
    parameter int OUTNEURON      = 16,
    parameter int INNEURON       = 64,
    parameter int PI             = 4,
    parameter int PO             = 2,
    parameter int RD_LATENCY     = 2,
    parameter int MAC_LATENCY    = 3,
    parameter int IN_ADDR_WIDTH  = 8,
    parameter int W_ADDR_WIDTH   = 12,
    parameter int OUT_ADDR_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      rden,
    output logic [IN_ADDR_WIDTH-1:0]  in_addr,
    output logic [W_ADDR_WIDTH-1:0]   weight_addr,
    output logic [3:0]                bank_sel,
    output logic                      enable_mult,
    output logic                      accum_sload,
    output logic                      out_wren,
    output logic [OUT_ADDR_WIDTH-1:0] out_addr
);

    localparam int BEATS      = INNEURON / 2;
    localparam int BANK_DEPTH = BEATS / PI;
    localparam int GROUPS     = OUTNEURON / PO;
    localparam int DRAIN_CYC  = RD_LATENCY + MAC_LATENCY;
    localparam int K_W        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int G_W        = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int D_W        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t         state, state_nx;
    logic [G_W-1:0] g, g_nx;
    logic [K_W-1:0] k, k_nx;
    logic [D_W-1:0] dcnt, dcnt_nx;
    logic           issue;    // a read beat is issued in the next cycle
    logic           last_wr;  // final group write accepted this cycle

    // Issue-side beat attributes, registered together with rden
    logic [3:0]     bank_iss;
    logic           first_iss;

    // Read-latency alignment pipeline
    logic           vld_p   [RD_LATENCY];
    logic [3:0]     bank_p  [RD_LATENCY];
    logic           first_p [RD_LATENCY];

    // ---------------- next-state / control ----------------
    always_comb begin
        state_nx = state;
        g_nx     = g;
        k_nx     = k;
        dcnt_nx  = dcnt;
        issue    = 1'b0;
        last_wr  = 1'b0;
        case (state)
            IDLE: begin
                g_nx = '0;
                k_nx = '0;
                if (start) begin
                    state_nx = READ;
                    issue    = 1'b1;
                end
            end
            READ: begin
                if (k == K_W'(BEATS - 1)) begin
                    state_nx = DRAIN;
                    dcnt_nx  = D_W'(DRAIN_CYC - 1);
                end else begin
                    k_nx  = k + K_W'(1);
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == '0) state_nx = WRITE;
                else            dcnt_nx  = dcnt - D_W'(1);
            end
            WRITE: begin
                if (out_ready) begin
                    if (g == G_W'(GROUPS - 1)) begin
                        state_nx = IDLE;
                        last_wr  = 1'b1;
                    end else begin
                        state_nx = READ;
                        g_nx     = g + G_W'(1);
                        k_nx     = '0;
                        issue    = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // abort overrides every transition, including a start in IDLE
        if (abort) begin
            state_nx = IDLE;
            g_nx     = '0;
            k_nx     = '0;
            issue    = 1'b0;
            last_wr  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            g        <= '0;
            k        <= '0;
            dcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_addr <= '0;
        end else begin
            state    <= state_nx;
            g        <= g_nx;
            k        <= k_nx;
            dcnt     <= dcnt_nx;
            busy     <= (state_nx != IDLE);
            done     <= last_wr;
            out_addr <= OUT_ADDR_WIDTH'(g_nx);
        end
    end

    // ---------------- issue stage ----------------
    // Groups occupy contiguous weight ranges, so the weight address simply
    // keeps counting across groups and only restarts at the start of a pass.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rden        <= 1'b0;
            in_addr     <= '0;
            weight_addr <= '0;
            bank_iss    <= '0;
            first_iss   <= 1'b0;
        end else begin
            rden <= issue;
            if (issue) begin
                first_iss <= (k_nx == '0);
                if (k_nx == '0) begin
                    in_addr     <= '0;
                    bank_iss    <= '0;
                    weight_addr <= (g_nx == '0) ? '0 : weight_addr + W_ADDR_WIDTH'(1);
                end else begin
                    weight_addr <= weight_addr + W_ADDR_WIDTH'(1);
                    if (in_addr == IN_ADDR_WIDTH'(BANK_DEPTH - 1)) begin
                        in_addr  <= '0;
                        bank_iss <= bank_iss + 4'd1;
                    end else begin
                        in_addr  <= in_addr + IN_ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

    // ---------------- data-alignment stages ----------------
    // Abort flushes beats still in flight so the MAC sees no stray enables.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_p[i]   <= 1'b0;
                bank_p[i]  <= '0;
                first_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0]   <= rden & ~abort;
            bank_p[0]  <= bank_iss;
            first_p[0] <= first_iss;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i]   <= vld_p[i-1] & ~abort;
                bank_p[i]  <= bank_p[i-1];
                first_p[i] <= first_p[i-1];
            end
        end
    end

    assign enable_mult = vld_p[RD_LATENCY-1];
    assign bank_sel    = bank_p[RD_LATENCY-1];
    assign accum_sload = vld_p[RD_LATENCY-1] & first_p[RD_LATENCY-1];

    // The only combinational output: the write strobe follows out_ready
    assign out_wren = (state == WRITE) & out_ready & ~abort;

endmodule

// File: tb/tb_fc_pass_scheduler.sv
module tb_fc_pass_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       out_ready = 1'b1;
    logic       busy, done, rden, enable_mult, accum_sload, out_wren;
    logic [7:0] in_addr;
    logic [11:0] weight_addr;
    logic [3:0] bank_sel;
    logic [7:0] out_addr;

    fc_pass_scheduler dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .out_ready(out_ready), .busy(busy), .done(done), .rden(rden),
        .in_addr(in_addr), .weight_addr(weight_addr), .bank_sel(bank_sel),
        .enable_mult(enable_mult), .accum_sload(accum_sload),
        .out_wren(out_wren), .out_addr(out_addr)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int c; int a; } wr_t;
    wr_t wr_q[$];
    int  done_q[$];
    wr_t wexp;
    int  dexp;
    int  n_rden = 0, n_wr = 0, n_done = 0, n_sload = 0;

    // Scoreboard: every write and done pulse is matched against the queues
    always @(negedge clock) begin
        if (rden) n_rden++;
        if (accum_sload) n_sload++;
        if (out_wren) begin
            n_wr++;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected cyc=%0d addr=%0d want no write", cyc, out_addr);
            end else begin
                wexp = wr_q.pop_front();
                if (cyc !== wexp.c || int'(out_addr) !== wexp.a) begin
                    errors++;
                    $display("FAIL write cyc=%0d addr=%0d want cyc=%0d addr=%0d", cyc, out_addr, wexp.c, wexp.a);
                end
            end
        end
        if (done) begin
            n_done++;
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d want no done", cyc);
            end else begin
                dexp = done_q.pop_front();
                if (cyc !== dexp) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, dexp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(output int t0);
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic push_pass(input int t0, input int stall_from, input int stall_len);
        wr_t e;
        for (int g = 0; g < 8; g++) begin
            e.c = t0 + 38 * (g + 1) + ((g >= stall_from) ? stall_len : 0);
            e.a = g;
            wr_q.push_back(e);
        end
        done_q.push_back(t0 + 305 + stall_len);
    endtask

    task automatic check_queues_empty(input string name);
        checks++;
        if (wr_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending writes=%0d dones=%0d want 0 0", name, wr_q.size(), done_q.size());
            wr_q.delete();
            done_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clock);
        checks++;
        if ({busy, done, rden, enable_mult, accum_sload, out_wren} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {busy, done, rden, enable_mult, accum_sload, out_wren});
        end
        checks++;
        if (in_addr !== 8'd0 || weight_addr !== 12'd0 || bank_sel !== 4'd0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_addr got in=%0d w=%0d bank=%0d out=%0d want 0", in_addr, weight_addr, bank_sel, out_addr);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Full pass with a stray start at cycle 100; cycle-accurate model check
    task automatic test_full_pass();
        int t0, wr0, dn0, sl0;
        int gr, of, ge, oe;
        logic exp_rden, exp_en, exp_busy;
        wr0 = n_wr; dn0 = n_done; sl0 = n_sload;
        push_pass(cyc, 8, 0);
        pulse_start(t0);
        for (int rel = 1; rel <= 310; rel++) begin
            if (rel > 1) tick();
            start = (rel == 100);
            @(negedge clock);
            gr = (rel - 1) / 38;
            of = (rel - 1) % 38;
            exp_rden = (gr < 8) && (of < 32);
            exp_busy = (rel <= 304);
            checks++;
            if (rden !== exp_rden || busy !== exp_busy) begin
                errors++;
                $display("FAIL pass_ctrl rel=%0d rden=%b busy=%b want %b %b", rel, rden, busy, exp_rden, exp_busy);
            end
            if (exp_rden) begin
                checks++;
                if (int'(weight_addr) !== gr * 32 + of || int'(in_addr) !== of % 8) begin
                    errors++;
                    $display("FAIL pass_addr rel=%0d w=%0d in=%0d want %0d %0d", rel, weight_addr, in_addr, gr * 32 + of, of % 8);
                end
            end
            exp_en = 1'b0;
            ge = 0; oe = 0;
            if (rel >= 3) begin
                ge = (rel - 3) / 38;
                oe = (rel - 3) % 38;
                exp_en = (ge < 8) && (oe < 32);
            end
            checks++;
            if (enable_mult !== exp_en || accum_sload !== (exp_en && oe == 0)) begin
                errors++;
                $display("FAIL pass_mac rel=%0d en=%b sload=%b want %b %b", rel, enable_mult, accum_sload, exp_en, exp_en && oe == 0);
            end
            if (exp_en) begin
                checks++;
                if (int'(bank_sel) !== oe / 8) begin
                    errors++;
                    $display("FAIL pass_bank rel=%0d got %0d want %0d", rel, bank_sel, oe / 8);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n_wr - wr0 !== 8 || n_done - dn0 !== 1 || n_sload - sl0 !== 8) begin
            errors++;
            $display("FAIL pass_counts writes=%0d dones=%0d sloads=%0d want 8 1 8", n_wr - wr0, n_done - dn0, n_sload - sl0);
        end
        check_queues_empty("pass_queue");
    endtask

    task automatic test_back_pressure();
        int t0, rd0;
        rd0 = n_rden;
        push_pass(cyc, 3, 10);
        pulse_start(t0);
        for (int rel = 1; rel <= 320; rel++) begin
            if (rel > 1) tick();
            out_ready = !(rel >= 152 && rel <= 161);
            @(negedge clock);
            if (rel >= 152 && rel <= 161) begin
                checks++;
                if (out_wren !== 1'b0 || out_addr !== 8'd3) begin
                    errors++;
                    $display("FAIL stall rel=%0d wren=%b addr=%0d want 0 3", rel, out_wren, out_addr);
                end
            end
        end
        out_ready = 1'b1;
        checks++;
        if (n_rden - rd0 !== 256) begin
            errors++;
            $display("FAIL stall_beats got %0d want 256", n_rden - rd0);
        end
        check_queues_empty("stall_queue");
    endtask

    // Short restart: checks the first beat and the group-0 write, then aborts
    task automatic restart_check(input string name);
        int t0;
        wr_t e;
        e.c = cyc + 38;
        e.a = 0;
        wr_q.push_back(e);
        pulse_start(t0);
        @(negedge clock);
        checks++;
        if (rden !== 1'b1 || weight_addr !== 12'd0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL %s rden=%b w=%0d addr=%0d want 1 0 0", name, rden, weight_addr, out_addr);
        end
        for (int rel = 2; rel <= 40; rel++) begin
            tick();
            abort = (rel == 40);
        end
        tick();
        abort = 1'b0;
        tick();
        check_queues_empty(name);
    endtask

    task automatic test_abort();
        int t0;
        wr_t e;
        for (int g = 0; g < 2; g++) begin
            e.c = cyc + 38 * (g + 1);
            e.a = g;
            wr_q.push_back(e);
        end
        pulse_start(t0);
        for (int rel = 1; rel <= 160; rel++) begin
            if (rel > 1) tick();
            abort = (rel == 90);
            @(negedge clock);
            if (rel == 91 || rel == 160) begin
                checks++;
                if (busy !== 1'b0 || rden !== 1'b0 || enable_mult !== 1'b0) begin
                    errors++;
                    $display("FAIL abort rel=%0d busy=%b rden=%b en=%b want 0 0 0", rel, busy, rden, enable_mult);
                end
            end
        end
        abort = 1'b0;
        check_queues_empty("abort_queue");
        tick();
        restart_check("abort_restart");
    endtask

    task automatic test_abort_start();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (busy !== 1'b0 || rden !== 1'b0) begin
                errors++;
                $display("FAIL abort_start i=%0d busy=%b rden=%b want 0 0", i, busy, rden);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain();
        int t0;
        pulse_start(t0);
        for (int rel = 2; rel <= 34; rel++) tick();
        checks++;
        if (busy !== 1'b1 || enable_mult !== 1'b1) begin
            errors++;
            $display("FAIL drain_pre busy=%b en=%b want 1 1", busy, enable_mult);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, rden, enable_mult, accum_sload, out_wren} !== 6'b0 ||
            in_addr !== 8'd0 || weight_addr !== 12'd0 || bank_sel !== 4'd0 || out_addr !== 8'd0) begin
            errors++;
            $display("FAIL async_reset ctrl=%b in=%0d w=%0d bank=%0d out=%0d want all 0",
                     {busy, done, rden, enable_mult, accum_sload, out_wren}, in_addr, weight_addr, bank_sel, out_addr);
        end
        tick();
        reset = 1'b0;
        tick();
        restart_check("reset_restart");
    endtask

    initial begin
        test_reset();
        test_full_pass();
        tick();
        tick();
        test_back_pressure();
        tick();
        test_abort();
        test_abort_start();
        test_reset_mid_drain();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_pass_scheduler.md
# fc_pass_scheduler

Sequencing controller for one fully-connected layer pass. On a `start` pulse it walks every output-neuron group (PO neurons per group). For each group it:
- issues the input-neuron and weight read beats,
- drives the PI-way bank select, the MAC enable and the accumulator sload,
- drains the read and MAC pipelines,
- writes the group result with a ready handshake.

It sits between the layer-level control and the FC memories/MAC array, replacing free-running enables with a start/busy/done protocol.

## Interface
- OUTNEURON, 16, output neurons per pass; must be a multiple of PO
- INNEURON, 64, input neurons; INNEURON/2 must be a multiple of PI
- PI, 4, input-neuron banks (1..16)
- PO, 2, output neurons computed per group
- RD_LATENCY, 2, cycles from rden to valid q data
- MAC_LATENCY, 3, cycles from last MAC input to valid accumulator output
- IN_ADDR_WIDTH, 8, input-neuron bank address width
- W_ADDR_WIDTH, 12, weight address width
- OUT_ADDR_WIDTH, 8, output-neuron address width
- Derived: BEATS = INNEURON/2; BANK_DEPTH = BEATS/PI; GROUPS = OUTNEURON/PO

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; all state and outputs cleared
- start  in  1  pass request; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE next cycle, no write, no done
- out_ready  in  1  result memory can accept a write this cycle
- busy  out  1  high from the cycle after an accepted start through the final write
- done  out  1  one-cycle pulse after the last group write
- rden  out  1  read enable for input-neuron ports a/b and weight ports a/b
- in_addr  out  IN_ADDR_WIDTH  input-neuron bank address (same on ports a and b)
- weight_addr  out  W_ADDR_WIDTH  weight address
- bank_sel  out  4  PI bank select for the q_a/q_b muxes, aligned to data
- enable_mult  out  1  MAC input valid, aligned to q data
- accum_sload  out  1  restart accumulation; high with the first valid beat of each group
- out_wren  out  1  result write strobe
- out_addr  out  OUT_ADDR_WIDTH  group index being written

## Operation
- States: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - `start` high moves to READ.
  - The group counter g and the beat counter k clear to 0.
- READ: one beat per cycle, for k = 0..BEATS-1.
  - rden = 1
  - in_addr = k mod BANK_DEPTH
  - weight_addr = g*BEATS + k
  - After k = BEATS-1, go to DRAIN.
- Data-side alignment:
  - Each issued beat is delayed RD_LATENCY cycles by a shift register.
  - The delayed beat drives enable_mult and bank_sel = k_delayed / BANK_DEPTH.
  - accum_sload is high when the delayed beat has k_delayed = 0.
- DRAIN: hold for RD_LATENCY+MAC_LATENCY cycles, counted by a down-counter, then go to WRITE.
- WRITE:
  - out_addr = g.
  - out_wren = out_ready; stay in WRITE while out_ready is low.
  - On the accepted write: if g = GROUPS-1, pulse done and go to IDLE. Otherwise g increments, k clears and the FSM returns to READ.
- abort takes priority over every transition. The next state is IDLE, and out_wren and done stay low.
- Simultaneous abort and start in IDLE: abort wins and the FSM stays in IDLE.
- start while busy is ignored.
- Address arithmetic is unsigned; weight_addr wraps modulo 2^W_ADDR_WIDTH. Parameter ranges must be chosen so that wrap does not occur.

## Timing
- Reset values: busy, done, rden, in_addr, weight_addr, bank_sel, enable_mult, accum_sload and out_wren = 0; out_addr = 0; the FSM is in IDLE.
- With start at cycle 0 and default parameters:
  - READ runs cycles 1–32.
  - enable_mult is high cycles 3–34; accum_sload is high at cycle 3.
  - DRAIN runs cycles 33–37.
  - WRITE is at cycle 38.
- Group period = BEATS + RD_LATENCY + MAC_LATENCY + 1 = 38 cycles when out_ready is held high. Each low cycle of out_ready adds one cycle.
- Default pass (out_ready high): the last write is at cycle 304, done pulses at cycle 305, busy falls at cycle 305.
- All outputs are registered. No combinational path from start, abort or out_ready to any output except out_wren = (state==WRITE) & out_ready.
- Asserting reset mid-pass clears everything immediately. After reset releases, the next start begins from group 0.

## Test plan
- Default parameters, start at cycle 0, out_ready = 1:
  - 8 writes at cycles 38, 76, …, 304 with out_addr 0..7.
  - done pulses only at cycle 305.
- Within group 1: weight_addr runs 32..63; in_addr cycles 0..7 four times.
- At the data side: bank_sel steps 0,1,2,3 every 8 enable_mult cycles; accum_sload is high exactly once per group.
- Hold out_ready low for 10 cycles at the group-3 write:
  - out_wren stays low throughout, and out_addr holds 3.
  - done shifts by 10 cycles to cycle 315.
  - No extra rden beats are issued.
- Assert abort during group 2 READ:
  - FSM is in IDLE next cycle; busy = 0, rden = 0.
  - No write occurs, done never pulses.
  - A new start restarts at g = 0.
- Assert asynchronous reset mid-DRAIN: all outputs read 0 immediately, before the next clock edge.
- Pulse start during the pass at cycle 100: it is ignored, and exactly 8 writes and 1 done occur.
